id_exe_pipe_reg: RTL and testbench
==================================

# id_exe_pipe_reg

Pipeline register between the decode stage and the execute stage of the ARM-subset core. It captures the control word produced by the control unit (`WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `B`, `S`, `EXE_CMD`) together with the decode-stage datapath fields, and presents them to execute one cycle later. It supports branch flush, hazard freeze and a valid bit, and keeps a saturating count of bubbles inserted into execute.

## Interface
Parameters:
- `WORD_W`, 32, width of PC and register operand fields
- `CNT_W`, 16, width of bubble counter

Ports:
- `clk`  in  1  rising-edge clock, only clock
- `rst`  in  1  reset; synchronous and active-high
- `flush`  in  1  branch taken; insert bubble
- `freeze`  in  1  hazard stall; hold current contents
- `valid_in`  in  1  decode slot holds a real instruction
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in`  in  1 each  control unit outputs
- `exe_cmd_in`  in  4  ALU command
- `pc_in`, `val_rn_in`, `val_rm_in`  in  WORD_W each  PC+4, Rn value, Rm value
- `imm_in`  in  1  immediate operand flag
- `shift_operand_in`  in  12  shifter operand field
- `signed_imm_24_in`  in  24  branch offset
- `dest_in`  in  4  destination register
- `sr_in`  in  4  status flags NZCV at decode
- `src1_in`, `src2_in`  in  4 each  source register numbers (used only with `FWD_SRC_EN`)
- `*_out`  out  same widths  registered copy of every `*_in` above, including `valid_out`
- `bubble_cnt`  out  CNT_W  saturating count of bubble cycles

## Operation
- Update priority, evaluated every rising edge: `rst` > `flush` > `freeze` > load.
- rst: every output goes to 0, including `valid_out`, `exe_cmd_out` and `bubble_cnt`.
- flush: all `*_out` fields go to 0, including datapath fields, and `valid_out` goes to 0. This is a bubble.
- freeze (flush=0): all `*_out` fields hold their values. `bubble_cnt` holds.
- load (flush=0, freeze=0): every `*_out` takes its `*_in`.
- Load with `valid_in`=0: control fields `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `b_out` and `s_out` are forced to 0, and `exe_cmd_out` is forced to 0. Datapath fields still load. `valid_out` goes to 0. This is a bubble.
- Invariant: `valid_out`=0 implies `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `b_out`, `s_out` and `exe_cmd_out` are all 0.
- Bubble counter:
  - Increments by 1 on every edge that writes a bubble (flush, or load with `valid_in`=0).
  - Saturates at 2^CNT_W−1 and never wraps.
  - rst clears it.
- No combinational path from any input to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `*_out` after edge N.
- flush and freeze in the same cycle: flush wins, and the bubble is counted.
- freeze held for k cycles: outputs are stable for k cycles, and the next load occurs on the first edge with freeze=0.
- rst asserted during freeze or flush: reset values apply on that edge. The first load happens on the first edge after rst deasserts.
- After reset release, output is a bubble until the first load with `valid_in`=1.

## Configuration
- Macro `FWD_SRC_EN`.
- Defined: `src1_out` and `src2_out` register `src1_in` and `src2_in` under the same priority rules. They are cleared to 0 on rst and flush, and held on freeze. They feed the forwarding unit.
- Undefined: `src1_in` and `src2_in` are ignored, and `src1_out` and `src2_out` are constant 0. The ports remain so the top level is unchanged.

## Test plan
- Reset: assert rst for 2 cycles with all inputs at 1 → every output is 0, `bubble_cnt`=0, `valid_out`=0.
- Load: `valid_in`=1, `wb_en_in`=1, `exe_cmd_in`=4'b0010, `pc_in`=32'h0000_0010, `dest_in`=4'd3 → one edge later the outputs show exactly those values, `valid_out`=1, `bubble_cnt` unchanged.
- Freeze: load `exe_cmd_in`=4'b0100, then hold freeze=1 for 3 cycles while the inputs change to 4'b0110 → `exe_cmd_out` stays 4'b0100 for 3 cycles; the cycle after freeze drops it shows 4'b0110.
- Flush beats freeze: flush=1 and freeze=1 with valid loaded contents `mem_w_en_out`=1 → next edge all outputs are 0, `valid_out`=0, `bubble_cnt` increments 0→1.
- Invalid load: `valid_in`=0, `wb_en_in`=1, `mem_r_en_in`=1, `exe_cmd_in`=4'b0010, `val_rn_in`=32'hDEAD_BEEF → control outputs are 0, `val_rn_out`=32'hDEAD_BEEF, `bubble_cnt`+1.
- Saturation and config:
  - With CNT_W=4, issue 20 consecutive flushes → `bubble_cnt` stops at 15.
  - With `FWD_SRC_EN`, `src1_in`=4'd7 loads to `src1_out`=7.
  - Without `FWD_SRC_EN`, `src1_out`=0.

Source files
------------

// File: rtl/id_exe_pipe_reg.sv
// rtl/id_exe_pipe_reg.sv - decode/execute pipeline register with flush, freeze, valid and bubble counter
// Optional macro FWD_SRC_EN registers source register numbers for the forwarding unit.
module id_exe_pipe_reg #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] val_rn_in,
    input  logic [WORD_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        sr_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        exe_cmd_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] val_rn_out,
    output logic [WORD_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        sr_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_load;

    // Saturating increment: stays at all-ones rather than wrapping.
    assign w_cnt_inc  = (r_bubble_cnt == '1) ? r_bubble_cnt : r_bubble_cnt + 1'b1;
    assign w_load     = !flush && !freeze;
    assign bubble_cnt = r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_out         <= 1'b0;
            wb_en_out         <= 1'b0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            exe_cmd_out       <= 4'd0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= 12'd0;
            signed_imm_24_out <= 24'd0;
            dest_out          <= 4'd0;
            sr_out            <= 4'd0;
        end else if (w_load) begin
            // An invalid slot still carries its datapath fields but no control effects.
            valid_out         <= valid_in;
            wb_en_out         <= wb_en_in    & valid_in;
            mem_r_en_out      <= mem_r_en_in & valid_in;
            mem_w_en_out      <= mem_w_en_in & valid_in;
            b_out             <= b_in        & valid_in;
            s_out             <= s_in        & valid_in;
            exe_cmd_out       <= exe_cmd_in  & {4{valid_in}};
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            dest_out          <= dest_in;
            sr_out            <= sr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (flush || (w_load && !valid_in)) begin
            r_bubble_cnt <= w_cnt_inc;
        end
    end

`ifdef FWD_SRC_EN
    logic [3:0] r_src1;
    logic [3:0] r_src2;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_src1 <= 4'd0;
            r_src2 <= 4'd0;
        end else if (w_load) begin
            r_src1 <= src1_in;
            r_src2 <= src2_in;
        end
    end

    assign src1_out = r_src1;
    assign src2_out = r_src2;
`else
    logic w_unused_src;

    assign w_unused_src = ^{src1_in, src2_in};
    assign src1_out     = 4'd0;
    assign src2_out     = 4'd0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb/tb_id_exe_pipe_reg.sv - scoreboard bench for id_exe_pipe_reg with random and directed stimulus
module tb_id_exe_pipe_reg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              valid;
        logic              wb;
        logic              mr;
        logic              mw;
        logic              b;
        logic              s;
        logic [3:0]        cmd;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] rn;
        logic [WORD_W-1:0] rm;
        logic              imm;
        logic [11:0]       shift;
        logic [23:0]       simm;
        logic [3:0]        dest;
        logic [3:0]        sr;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [CNT_W-1:0]  cnt;
    } out_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0, flush = 1'b0, freeze = 1'b0, valid_in = 1'b0;
    logic              wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;
    logic [3:0]        exe_cmd_in = 4'd0;
    logic [WORD_W-1:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
    logic              imm_in = 1'b0;
    logic [11:0]       shift_operand_in = '0;
    logic [23:0]       signed_imm_24_in = '0;
    logic [3:0]        dest_in = '0, sr_in = '0, src1_in = '0, src2_in = '0;

    logic              valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [3:0]        exe_cmd_out, dest_out, sr_out, src1_out, src2_out;
    logic [WORD_W-1:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm_24_out;
    logic [CNT_W-1:0]  bubble_cnt;

    id_exe_pipe_reg #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .sr_in(sr_in), .src1_in(src1_in), .src2_in(src2_in),
        .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .sr_out(sr_out),
        .src1_out(src1_out), .src2_out(src2_out), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    out_t model = '0;
    int   model_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: the expected register contents follow directly from the update rules.
    task automatic step_model();
        out_t nxt;
        nxt = model;
        if (rst) begin
            nxt = '0;
            model_cnt = 0;
        end else if (flush) begin
            nxt = '0;
            if (model_cnt < CNT_MAX) model_cnt++;
        end else if (!freeze) begin
            nxt.valid = valid_in;
            nxt.pc = pc_in; nxt.rn = val_rn_in; nxt.rm = val_rm_in;
            nxt.imm = imm_in; nxt.shift = shift_operand_in; nxt.simm = signed_imm_24_in;
            nxt.dest = dest_in; nxt.sr = sr_in;
`ifdef FWD_SRC_EN
            nxt.src1 = src1_in; nxt.src2 = src2_in;
`else
            nxt.src1 = 4'd0; nxt.src2 = 4'd0;
`endif
            if (valid_in) begin
                nxt.wb = wb_en_in; nxt.mr = mem_r_en_in; nxt.mw = mem_w_en_in;
                nxt.b = b_in; nxt.s = s_in; nxt.cmd = exe_cmd_in;
            end else begin
                nxt.wb = 0; nxt.mr = 0; nxt.mw = 0; nxt.b = 0; nxt.s = 0; nxt.cmd = 4'd0;
                if (model_cnt < CNT_MAX) model_cnt++;
            end
        end
        nxt.cnt = model_cnt[CNT_W-1:0];
        model = nxt;
    endtask

    task automatic apply(input logic r, input logic f, input logic z, input logic v);
        rst = r; flush = f; freeze = z; valid_in = v;
        @(posedge clk);
        step_model();
        exp_q.push_back(model);
        #1;
    endtask

    task automatic rand_fields();
        wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
        b_in = 1'($urandom); s_in = 1'($urandom); exe_cmd_in = 4'($urandom);
        pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        imm_in = 1'($urandom); shift_operand_in = 12'($urandom);
        signed_imm_24_in = 24'($urandom); dest_in = 4'($urandom); sr_in = 4'($urandom);
        src1_in = 4'($urandom); src2_in = 4'($urandom);
    endtask

    task automatic set_all_ones();
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1;
        exe_cmd_in = '1; pc_in = '1; val_rn_in = '1; val_rm_in = '1; imm_in = 1;
        shift_operand_in = '1; signed_imm_24_in = '1; dest_in = '1; sr_in = '1;
        src1_in = '1; src2_in = '1;
    endtask

    task automatic clear_fields();
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
        exe_cmd_in = '0; pc_in = '0; val_rn_in = '0; val_rm_in = '0; imm_in = 0;
        shift_operand_in = '0; signed_imm_24_in = '0; dest_in = '0; sr_in = '0;
        src1_in = '0; src2_in = '0;
    endtask

    // Monitor: the register presents a new word every cycle, checked 3 time units after the edge.
    initial begin
        out_t act, exp;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                act = '{valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                        exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
                        shift_operand_out, signed_imm_24_out, dest_out, sr_out,
                        src1_out, src2_out, bubble_cnt};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, exp);
                end
                vectors++;
                if (!valid_out && ({wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out} !== 9'd0)) begin
                    miscompares++;
                    $display("FAIL bubble_ctrl t=%0t actual=%b required=0", $time,
                             {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out});
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Reset with every input high.
        set_all_ones();
        apply(1, 1, 1, 1);
        apply(1, 1, 1, 1);
        // Valid load.
        clear_fields();
        wb_en_in = 1; exe_cmd_in = 4'b0010; pc_in = 32'h0000_0010; dest_in = 4'd3;
        apply(0, 0, 0, 1);
        // Freeze for three cycles while inputs change.
        exe_cmd_in = 4'b0100;
        apply(0, 0, 0, 1);
        exe_cmd_in = 4'b0110;
        repeat (3) apply(0, 0, 1, 1);
        apply(0, 0, 0, 1);
        // Flush beats freeze on valid contents with a store.
        mem_w_en_in = 1;
        apply(0, 0, 0, 1);
        apply(0, 1, 1, 1);
        // Invalid load keeps datapath but drops control.
        clear_fields();
        wb_en_in = 1; mem_r_en_in = 1; exe_cmd_in = 4'b0010; val_rn_in = 32'hDEAD_BEEF;
        apply(0, 0, 0, 0);
        // Counter saturation.
        repeat (20) apply(0, 1, 0, 1);
        // Source register fields.
        src1_in = 4'd7; src2_in = 4'd9;
        apply(0, 0, 0, 1);
        // Reset during freeze and flush.
        apply(1, 0, 1, 1);
        apply(1, 1, 0, 1);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_fields();
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end
        rst = 0; flush = 0; freeze = 1;
        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
